// File: rtl/perip_bridge_if.sv
// Core-side peripheral bus: byte address, store strobe/mask/data and combinational read data.
interface perip_bridge_if;
  logic [31:0] perip_addr;
  logic        perip_wen;
  logic [1:0]  perip_mask;
  logic [31:0] perip_wdata;
  logic [31:0] perip_rdata;

  modport master (
    output perip_addr,
    output perip_wen,
    output perip_mask,
    output perip_wdata,
    input  perip_rdata
  );

  modport slave (
    input  perip_addr,
    input  perip_wen,
    input  perip_mask,
    input  perip_wdata,
    output perip_rdata
  );
endinterface

// File: rtl/perip_bridge.sv
// perip_bridge: data-side responder for DRAM, switches, keys, 7-seg, LEDs and a millisecond counter.
// The counter is built only when PERIP_CNT_EN is defined; otherwise CNT reads 0 and ignores writes.
module perip_bridge #(
  parameter int DRAM_AW     = 16,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int SW_W        = 16,
  parameter int LED_W       = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  perip_bridge_if.slave    bus,
  input  logic [SW_W-1:0]  sw,
  input  logic [4:0]       key,
  output logic [LED_W-1:0] led,
  output logic [31:0]      seg_data
);

  localparam logic [31:0] DRAM_BASE = 32'h8010_0000;
  localparam logic [32:0] DRAM_SPAN = 33'd4 << DRAM_AW;
  localparam logic [31:0] SW_ADDR   = 32'h8020_0000;
  localparam logic [31:0] KEY_ADDR  = 32'h8020_0010;
  localparam logic [31:0] SEG_ADDR  = 32'h8020_0020;
  localparam logic [31:0] LED_ADDR  = 32'h8020_0040;
  localparam logic [31:0] CNT_ADDR  = 32'h8020_0050;

  if (CLK_FREQ_HZ < 1000) begin : g_bad_clk
    $error("perip_bridge: CLK_FREQ_HZ must be at least 1000");
  end

  // Byte-lane enables for a store; misaligned halves/words and mask 11 yield no lanes.
  function automatic logic [3:0] lane_enables(input logic [1:0] mask, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0000;
    case (mask)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   if (lo[0] == 1'b0) be = lo[1] ? 4'b1100 : 4'b0011; else be = 4'b0000;
      2'b10:   if (lo == 2'b00) be = 4'b1111; else be = 4'b0000;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8]; else res[i*8 +: 8] = old_w[i*8 +: 8];
    end
    return res;
  endfunction

  logic [31:0]        addr_s;
  logic [31:0]        addr_word_s;
  logic [31:0]        dram_off_s;
  logic               dram_hit_s;
  logic [DRAM_AW-1:0] dram_idx_s;
  logic [3:0]         wr_be_s;
  logic [31:0]        lane_data_s;
  logic [31:0]        rdata_s;
  logic [31:0]        sw_word_s;
  logic [31:0]        cnt_value_s;
  logic [LED_W-1:0]   led_nxt_s;
  logic [LED_W-1:0]   led_r;
  logic [31:0]        seg_r;
  logic [SW_W-1:0]    sw_meta_r, sw_sync_r;
  logic [4:0]         key_meta_r, key_sync_r;
  logic [31:0]        dram_mem [0:(2**DRAM_AW)-1];

  assign addr_s      = bus.perip_addr;
  assign addr_word_s = {addr_s[31:2], 2'b00};
  assign dram_off_s  = addr_s - DRAM_BASE;
  assign dram_hit_s  = (addr_s >= DRAM_BASE) && ({1'b0, dram_off_s} < DRAM_SPAN);
  assign dram_idx_s  = addr_s[DRAM_AW+1:2];
  assign wr_be_s     = bus.perip_wen ? lane_enables(bus.perip_mask, addr_s[1:0]) : 4'b0000;

  // Right-aligned store data replicated onto every lane it may target.
  always_comb begin
    lane_data_s = bus.perip_wdata;
    case (bus.perip_mask)
      2'b00:   lane_data_s = {4{bus.perip_wdata[7:0]}};
      2'b01:   lane_data_s = {2{bus.perip_wdata[15:0]}};
      default: lane_data_s = bus.perip_wdata;
    endcase
  end

  // DRAM: synchronous byte-enabled write, no reset.
  always_ff @(posedge cpu_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dram_hit_s && cpu_rst && wr_be_s[i]) begin
        dram_mem[dram_idx_s][i*8 +: 8] <= lane_data_s[i*8 +: 8];
      end
    end
  end

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      sw_meta_r  <= {SW_W{1'b0}};
      sw_sync_r  <= {SW_W{1'b0}};
      key_meta_r <= 5'b00000;
      key_sync_r <= 5'b00000;
    end else begin
      sw_meta_r  <= sw;
      sw_sync_r  <= sw_meta_r;
      key_meta_r <= key;
      key_sync_r <= key_meta_r;
    end
  end

  // LED register keeps only its low LED_W bits, lane-merged bit by bit.
  always_comb begin
    led_nxt_s = led_r;
    for (int j = 0; j < LED_W; j++) begin
      if ((addr_word_s == LED_ADDR) && wr_be_s[j/8]) led_nxt_s[j] = lane_data_s[j];
      else led_nxt_s[j] = led_r[j];
    end
  end

  // SEG and LED output registers.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      led_r <= {LED_W{1'b0}};
      seg_r <= 32'h0000_0000;
    end else begin
      led_r <= led_nxt_s;
      if (addr_word_s == SEG_ADDR) seg_r <= merge_lanes(seg_r, lane_data_s, wr_be_s);
      else seg_r <= seg_r;
    end
  end

  assign led      = led_r;
  assign seg_data = seg_r;

`ifdef PERIP_CNT_EN
  localparam int unsigned PRESC_TC = CLK_FREQ_HZ / 1000;
  localparam int          PRESC_W  = (PRESC_TC > 1) ? $clog2(PRESC_TC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_TC - 1);

  typedef enum logic [0:0] {CNT_IDLE = 1'b0, CNT_RUN = 1'b1} cnt_state_e;

  cnt_state_e         cnt_state_r, cnt_state_nxt_s;
  logic [PRESC_W-1:0] presc_r, presc_nxt_s;
  logic [31:0]        ms_r, ms_nxt_s;
  logic               cnt_word_wr_s, cnt_start_s, cnt_stop_s;

  // Only aligned full-word stores carry counter commands.
  assign cnt_word_wr_s = (addr_word_s == CNT_ADDR) && (wr_be_s == 4'b1111);
  assign cnt_start_s   = cnt_word_wr_s && (bus.perip_wdata == 32'h8000_0000);
  assign cnt_stop_s    = cnt_word_wr_s && (bus.perip_wdata == 32'hFFFF_FFFF);

  // Counter FSM state, prescaler and millisecond count registers.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      cnt_state_r <= CNT_IDLE;
      presc_r     <= {PRESC_W{1'b0}};
      ms_r        <= 32'h0000_0000;
    end else begin
      cnt_state_r <= cnt_state_nxt_s;
      presc_r     <= presc_nxt_s;
      ms_r        <= ms_nxt_s;
    end
  end

  // Counter next state: restart wins over stop, stop wins over the tick.
  always_comb begin
    cnt_state_nxt_s = cnt_state_r;
    presc_nxt_s     = presc_r;
    ms_nxt_s        = ms_r;
    case (cnt_state_r)
      CNT_IDLE: begin
        if (cnt_start_s) begin
          cnt_state_nxt_s = CNT_RUN;
          presc_nxt_s     = {PRESC_W{1'b0}};
          ms_nxt_s        = 32'h0000_0000;
        end else begin
          cnt_state_nxt_s = CNT_IDLE;
        end
      end
      CNT_RUN: begin
        if (cnt_start_s) begin
          presc_nxt_s = {PRESC_W{1'b0}};
          ms_nxt_s    = 32'h0000_0000;
        end else if (cnt_stop_s) begin
          cnt_state_nxt_s = CNT_IDLE;
        end else if (presc_r == PRESC_LAST) begin
          presc_nxt_s = {PRESC_W{1'b0}};
          ms_nxt_s    = ms_r + 32'd1;
        end else begin
          presc_nxt_s = presc_r + PRESC_W'(1);
        end
      end
      default: begin
        cnt_state_nxt_s = CNT_IDLE;
        presc_nxt_s     = {PRESC_W{1'b0}};
        ms_nxt_s        = 32'h0000_0000;
      end
    endcase
  end

  assign cnt_value_s = ms_r;
`else
  assign cnt_value_s = 32'h0000_0000;
`endif

  // Zero-extend the synchronized switches to a bus word.
  always_comb begin
    sw_word_s = 32'h0000_0000;
    sw_word_s[SW_W-1:0] = sw_sync_r;
  end

  // Combinational read mux on the aligned word address.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (dram_hit_s) begin
      rdata_s = dram_mem[dram_idx_s];
    end else if (addr_word_s == SW_ADDR) begin
      rdata_s = sw_word_s;
    end else if (addr_word_s == KEY_ADDR) begin
      rdata_s = {27'h000_0000, key_sync_r};
    end else if (addr_word_s == SEG_ADDR) begin
      rdata_s = seg_r;
    end else if (addr_word_s == LED_ADDR) begin
      rdata_s = 32'h0000_0000;
      rdata_s[LED_W-1:0] = led_r;
    end else if (addr_word_s == CNT_ADDR) begin
      rdata_s = cnt_value_s;
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.perip_rdata = rdata_s;

endmodule

// File: tb/tb_perip_bridge.sv
// Self-checking bench for perip_bridge: behavioural map model, per-cycle compare, directed literals.
module tb_perip_bridge;
  localparam int DRAM_AW     = 8;
  localparam int CLK_FREQ_HZ = 4000;
  localparam int SW_W        = 16;
  localparam int LED_W       = 16;
  localparam int TC          = CLK_FREQ_HZ / 1000;
  localparam int DRAM_BYTES  = 4 * (1 << DRAM_AW);
`ifdef PERIP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             cpu_clk = 1'b0;
  logic             cpu_rst = 1'b0;
  logic [SW_W-1:0]  sw = '0;
  logic [4:0]       key = '0;
  logic [LED_W-1:0] led;
  logic [31:0]      seg_data;

  perip_bridge_if bus();

  perip_bridge #(.DRAM_AW(DRAM_AW), .CLK_FREQ_HZ(CLK_FREQ_HZ), .SW_W(SW_W), .LED_W(LED_W)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus),
    .sw      (sw),
    .key     (key),
    .led     (led),
    .seg_data(seg_data)
  );

  always #5 cpu_clk = ~cpu_clk;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  // Model state
  logic [7:0]       m_dram [int];
  logic [31:0]      m_seg;
  logic [15:0]      m_led;
  logic [15:0]      m_sw_q [2];
  logic [4:0]       m_key_q [2];
  bit               m_running;
  int               m_edges;
  int               m_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input logic [31:0] known);
    checks++;
    if (((act ^ exp) & known) != 32'h0) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h care=%h t=%0t", name, act, exp, known, $time);
    end
  endtask

  function automatic void model_reset();
    m_seg = 32'h0; m_led = 16'h0;
    m_sw_q[0] = 16'h0; m_sw_q[1] = 16'h0;
    m_key_q[0] = 5'h0; m_key_q[1] = 5'h0;
    m_running = 1'b0; m_edges = 0; m_hold = 0;
  endfunction

  function automatic int cnt_now();
    if (!CNT_EN) return 0;
    return m_running ? (m_edges / TC) : m_hold;
  endfunction

  function automatic bit in_dram(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h8010_0000;
    return (a >= 32'h8010_0000) && (off < 32'(DRAM_BYTES));
  endfunction

  function automatic bit lane_written(input logic [1:0] lo, input logic [1:0] mask, input int b);
    case (mask)
      2'b00:   return b == int'(lo);
      2'b01:   return (lo[0] == 1'b0) && ((b / 2) == int'(lo[1]));
      2'b10:   return lo == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] lane_byte(input logic [1:0] mask, input logic [31:0] d, input int b);
    if (mask == 2'b00) return d[7:0];
    if (mask == 2'b01) return d[8*(b%2) +: 8];
    return d[8*b +: 8];
  endfunction

  function automatic void model_read(input logic [31:0] a, output logic [31:0] v, output logic [31:0] known);
    logic [31:0] wa;
    int base;
    wa = {a[31:2], 2'b00};
    v = 32'h0; known = 32'hFFFF_FFFF;
    if (in_dram(a)) begin
      base = int'(wa - 32'h8010_0000);
      for (int b = 0; b < 4; b++) begin
        if (m_dram.exists(base + b)) v[8*b +: 8] = m_dram[base + b];
        else known[8*b +: 8] = 8'h00;
      end
    end else begin
      case (wa)
        32'h8020_0000: v = {16'h0, m_sw_q[1]};
        32'h8020_0010: v = {27'h0, m_key_q[1]};
        32'h8020_0020: v = m_seg;
        32'h8020_0040: v = {16'h0, m_led};
        32'h8020_0050: v = 32'(cnt_now());
        default:       v = 32'h0;
      endcase
    end
  endfunction

  // One clock edge of the map as seen from the spec's rules.
  function automatic void model_edge();
    logic [31:0] a, d, wa, lw;
    logic [1:0]  mask;
    bit          wen, ctl_word;
    int          base;
    a = bus.perip_addr; d = bus.perip_wdata; mask = bus.perip_mask; wen = bus.perip_wen;
    wa = {a[31:2], 2'b00};
    ctl_word = wen && (wa == 32'h8020_0050) && (mask == 2'b10) && (a[1:0] == 2'b00);
    if (ctl_word && d == 32'h8000_0000) begin
      m_running = 1'b1; m_edges = 0;
    end else if (ctl_word && d == 32'hFFFF_FFFF) begin
      if (m_running) m_hold = m_edges / TC;
      m_running = 1'b0;
    end else if (m_running) begin
      m_edges++;
    end
    if (wen) begin
      if (in_dram(a)) begin
        base = int'(wa - 32'h8010_0000);
        for (int b = 0; b < 4; b++)
          if (lane_written(a[1:0], mask, b)) m_dram[base + b] = lane_byte(mask, d, b);
      end else if (wa == 32'h8020_0020) begin
        for (int b = 0; b < 4; b++)
          if (lane_written(a[1:0], mask, b)) m_seg[8*b +: 8] = lane_byte(mask, d, b);
      end else if (wa == 32'h8020_0040) begin
        lw = {16'h0, m_led};
        for (int b = 0; b < 4; b++)
          if (lane_written(a[1:0], mask, b)) lw[8*b +: 8] = lane_byte(mask, d, b);
        m_led = lw[15:0];
      end
    end
    m_sw_q[1] = m_sw_q[0]; m_sw_q[0] = sw;
    m_key_q[1] = m_key_q[0]; m_key_q[0] = key;
  endfunction

  task automatic tick();
    @(posedge cpu_clk);
    if (cpu_rst) model_edge();
    #1;
  endtask

  task automatic set_bus(input logic [31:0] a, input logic w, input logic [1:0] m, input logic [31:0] d);
    bus.perip_addr = a; bus.perip_wen = w; bus.perip_mask = m; bus.perip_wdata = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
    set_bus(a, 1'b1, m, d);
    tick();
    set_bus(a, 1'b0, 2'b10, 32'h0);
  endtask

  // Directed read: compares both the DUT and the model against a hand-computed literal.
  task automatic lit(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] mv, mk;
    set_bus(a, 1'b0, 2'b10, 32'h0);
    #1;
    check(name, bus.perip_rdata, exp, 32'hFFFF_FFFF);
    model_read(a, mv, mk);
    check({name, "_model"}, mv, exp, mk);
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge cpu_clk) begin
    logic [31:0] ev, ek;
    if (checking) begin
      model_read(bus.perip_addr, ev, ek);
      check("rdata", bus.perip_rdata, ev, ek);
      check("led", {16'h0, led}, {16'h0, m_led}, 32'hFFFF_FFFF);
      check("seg", seg_data, m_seg, 32'hFFFF_FFFF);
    end
  end

  logic [31:0] pool [10] = '{32'h8010_0000, 32'h8010_0010, 32'h8010_03F8, 32'h8010_0400,
                             32'h8020_0000, 32'h8020_0010, 32'h8020_0020, 32'h8020_0040,
                             32'h8020_0050, 32'h8030_0000};

  initial begin
    model_reset();
    set_bus(32'h8020_0000, 1'b0, 2'b10, 32'h0);
    #2;
    checking = 1'b1;
    check("led_rst", {16'h0, led}, 32'h0, 32'hFFFF_FFFF);
    check("seg_rst", seg_data, 32'h0, 32'hFFFF_FFFF);
    lit("sw_rst", 32'h8020_0000, 32'h0);
    tick(); tick();
    cpu_rst = 1'b1;

    // DRAM lane rules
    wr(32'h8010_0004, 2'b10, 32'hDEAD_BEEF);
    wr(32'h8010_0006, 2'b00, 32'h0000_0011);
    lit("dram_byte", 32'h8010_0004, 32'hDE11_BEEF);
    wr(32'h8010_0008, 2'b10, 32'h0123_4567);
    wr(32'h8010_0009, 2'b01, 32'h0000_ABCD);
    lit("dram_half_misal", 32'h8010_0008, 32'h0123_4567);
    wr(32'h8010_000A, 2'b01, 32'h0000_ABCD);
    lit("dram_half_hi", 32'h8010_0008, 32'hABCD_4567);
    wr(32'h8010_000C, 2'b10, 32'h1111_1111);
    wr(32'h8010_000E, 2'b10, 32'h2222_2222);
    lit("dram_word_misal", 32'h8010_000C, 32'h1111_1111);
    wr(32'h8010_0000, 2'b10, 32'h5A5A_5A5A);
    wr(32'h8010_0400, 2'b10, 32'hFFFF_FFFF);
    lit("dram_past_end", 32'h8010_0400, 32'h0);
    lit("dram_no_alias", 32'h8010_0000, 32'h5A5A_5A5A);
    wr(32'h8010_03FC, 2'b10, 32'h600D_CAFE);
    lit("dram_last", 32'h8010_03FE, 32'h600D_CAFE);

    // Synchronizer latency
    sw = 16'h00A5;
    set_bus(32'h8020_0000, 1'b0, 2'b10, 32'h0);
    tick();
    lit("sw_1edge", 32'h8020_0000, 32'h0);
    tick();
    lit("sw_2edge", 32'h8020_0000, 32'h0000_00A5);
    key = 5'h13; tick(); tick();
    lit("key", 32'h8020_0013, 32'h0000_0013);

    // LED / SEG / unmapped
    wr(32'h8020_0040, 2'b10, 32'h0000_1234);
    check("led_word", {16'h0, led}, 32'h0000_1234, 32'hFFFF_FFFF);
    wr(32'h8020_0041, 2'b00, 32'h0000_0099);
    lit("led_byte", 32'h8020_0040, 32'h0000_9934);
    wr(32'h8020_0020, 2'b10, 32'hCAFE_F00D);
    wr(32'h8020_0020, 2'b11, 32'h0000_0000);
    lit("seg_mask11", 32'h8020_0020, 32'hCAFE_F00D);
    wr(32'h8020_0023, 2'b00, 32'h0000_0077);
    lit("seg_byte", 32'h8020_0020, 32'h77FE_F00D);
    lit("unmapped", 32'h8030_0000, 32'h0);
    wr(32'h8020_0000, 2'b10, 32'hFFFF_FFFF);
    lit("sw_ro", 32'h8020_0000, 32'h0000_00A5);

    // Millisecond counter (prescale 4)
    wr(32'h8020_0050, 2'b10, 32'h8000_0000);
    repeat (12) tick();
    lit("cnt_run12", 32'h8020_0050, CNT_EN ? 32'd3 : 32'd0);
    wr(32'h8020_0050, 2'b10, 32'h1234_5678);
    wr(32'h8020_0050, 2'b10, 32'hFFFF_FFFF);
    repeat (20) tick();
    lit("cnt_hold", 32'h8020_0050, CNT_EN ? 32'd3 : 32'd0);
    wr(32'h8020_0050, 2'b10, 32'h8000_0000);
    lit("cnt_restart", 32'h8020_0050, 32'd0);
    repeat (6) tick();
    wr(32'h8020_0040, 2'b10, 32'h0000_FFFF);

    // Asynchronous reset mid-cycle
    #2;
    cpu_rst = 1'b0;
    model_reset();
    #1;
    check("led_async_rst", {16'h0, led}, 32'h0, 32'hFFFF_FFFF);
    check("seg_async_rst", seg_data, 32'h0, 32'hFFFF_FFFF);
    lit("cnt_rst", 32'h8020_0050, 32'h0);
    tick();
    cpu_rst = 1'b1;
    repeat (10) tick();
    lit("cnt_idle_after_rst", 32'h8020_0050, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int idx;
      logic [31:0] a, d;
      logic [1:0] lo;
      idx = $urandom_range(0, 10);
      a = (idx == 10) ? 32'h800F_FFFC : pool[idx];
      if (idx <= 1) a = a + 32'(4 * $urandom_range(0, 3));
      lo = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      a = {a[31:2], lo};
      d = $urandom;
      if (idx == 8) begin
        case ($urandom_range(0, 5))
          0: d = 32'h8000_0000;
          1: d = 32'hFFFF_FFFF;
          default: d = $urandom;
        endcase
      end
      if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
      if ($urandom_range(0, 3) == 0) key = 5'($urandom);
      set_bus(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d);
      tick();
    end

    set_bus(32'h8030_0000, 1'b0, 2'b10, 32'h0);
    tick();
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/perip_bridge.md
Name: perip_bridge

Overview:
Responder for the core's data-side peripheral bus: perip_addr / perip_wen / perip_mask / perip_wdata / perip_rdata.
- Decodes each access to one of: on-chip DRAM, switch/key inputs, LED register, 7-seg register, millisecond counter.
- Sits between the core's memory stage and board I/O.
- Reads are combinational, so the MEM stage gets data in the same cycle. Writes commit on the clock edge.

Parameters:
DRAM_AW, 16, DRAM word-address width (depth = 2^DRAM_AW words)
CLK_FREQ_HZ, 50000000, cpu_clk frequency; sets the ms prescaler terminal count
SW_W, 16, switch input width
LED_W, 16, LED output width

Ports:
cpu_clk  input  1  clock; all state updates on rising edge
cpu_rst  input  1  asynchronous, active-low reset
perip_addr  input  32  byte address from core
perip_wen  input  1  write enable, one cycle per store
perip_mask  input  2  00 byte, 01 halfword, 10 word, 11 reserved (write ignored)
perip_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
perip_rdata  output  32  aligned word at perip_addr & ~3, combinational
sw  input  SW_W  board switches, asynchronous
key  input  5  board keys, asynchronous
led  output  LED_W  LED register
seg_data  output  32  7-seg display word (8 hex nibbles)

Behaviour:
Address map; unmapped reads return 0 and unmapped writes are dropped:
- DRAM 0x8010_0000 + up to 4*2^DRAM_AW bytes.
- SW 0x8020_0000 (RO): zero-extended synchronized sw.
- KEY 0x8020_0010 (RO): zero-extended synchronized key.
- SEG 0x8020_0020 (RW).
- LED 0x8020_0040 (RW): low LED_W bits.
- CNT 0x8020_0050 (RW control, RO value).

Reads:
- perip_rdata is a pure function of perip_addr and current state. Zero-cycle latency.
- Always returns the full aligned word. Byte/half extraction and sign extension are done by the core.
- A read in the same cycle as a write to the same address returns the old value. No write-through.

Writes (perip_wen=1), applied at the edge, lane from perip_addr[1:0]:
- byte: wdata[7:0] goes to lane addr[1:0].
- half: wdata[15:0] goes to lanes {addr[1],0}; addr[0]=1 means misaligned, write dropped.
- word: addr[1:0] must be 00, else dropped.
- mask 11 is dropped.
- SEG and LED accept masked writes with the same lane rules.

Input synchronization:
- sw and key pass through a 2-flop synchronizer, reset to 0.
- Reads see an input change 2 edges after it.

Counter FSM (states IDLE, RUN):
- Reset: IDLE, prescaler=0, ms_count=0.
- Word write 0x8000_0000 to CNT: clear ms_count and prescaler, enter RUN. This restart also applies when already in RUN.
- Word write 0xFFFF_FFFF to CNT: enter IDLE and hold ms_count. Any other CNT write is ignored.
- In RUN, prescaler counts 0..CLK_FREQ_HZ/1000-1. On terminal count it wraps to 0 and ms_count increments.
- ms_count is 32-bit and wraps 0xFFFF_FFFF to 0 silently.
- Reading CNT returns ms_count.

DRAM:
- Inferred as synchronous-write, asynchronous-read RAM with 4 byte enables.
- Not reset; contents undefined after reset unless initialized.
- Index = perip_addr[DRAM_AW+1:2].

Reset values (async, cpu_rst=0): led=0, seg_data=0, sync flops=0, counter IDLE/0. perip_rdata follows the reset register values.
- Reset asserted mid-write: the write is lost. DRAM lanes are undefined only for that cycle's write.

Optional Feature:
PERIP_CNT_EN
- Defined: counter FSM, prescaler and CNT decode are present as specified.
- Undefined: no counter logic is synthesized, CNT reads 0 and CNT writes are ignored. The rest of the map is unchanged.

Test Plan:
- DRAM word write 0xDEADBEEF @0x8010_0004, then byte write 0x11 @0x8010_0006 -> read 0x8010_0004 returns 0xDE11BEEF.
- Half write 0xABCD @0x8010_0009 (misaligned) -> 0x8010_0008 unchanged. Half write @0x8010_000A -> upper half becomes 0xABCD.
- sw=0x00A5 applied -> SW read is 0 after 1 edge and 0x0000_00A5 after 2 edges. LED word write 0x1234 -> led=0x1234 next cycle. Unmapped 0x8030_0000 reads 0.
- CLK_FREQ_HZ=4000 (prescale 4): CNT write 0x8000_0000, wait 12 cycles -> CNT=3. Write 0xFFFF_FFFF, wait 20 -> CNT still 3. Write 0x8000_0000 -> CNT reads 0.
- cpu_rst low for 1 cycle mid-run with led=0xFFFF, counter RUN -> led=0, seg_data=0, CNT=0 and stays 0 (IDLE) after release.
- Build without PERIP_CNT_EN -> CNT write 0x8000_0000 then 100 cycles -> CNT read 0, DRAM/LED tests unchanged.
